// File: rtl/spi_req_arbiter_if.sv
// Request/SPI-master bundle for spi_req_arbiter.
// slave: arbiter side; master: requesters plus SPI master side.
interface spi_req_arbiter_if;
  logic [3:0]  req;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic [15:0] wdata2;
  logic [15:0] wdata3;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [1:0]  dev_sel;
  logic        m_start;
  logic [15:0] m_data;
  logic        m_done;
  logic        m_abort;

  modport slave (
    input  req, wdata0, wdata1, wdata2, wdata3, m_done,
    output grant, ack, err, dev_sel, m_start, m_data, m_abort
  );

  modport master (
    output req, wdata0, wdata1, wdata2, wdata3, m_done,
    input  grant, ack, err, dev_sel, m_start, m_data, m_abort
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among 4 requesters.
// Ports: clk, rst (async high), bus (req/wdata in, grant/ack/err/m_* out).
module spi_req_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  spi_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  state_t      state;
  logic [1:0]  last_owner;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  logic [15:0] win_data;
  logic [7:0]  tcnt;
  logic [3:0]  gcnt;

  // Search upward from last_owner+1; i==4 wraps to last_owner itself,
  // so a lone requester that just finished can still win.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_owner + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = bus.wdata0;
    unique case (win)
      2'd0: win_data = bus.wdata0;
      2'd1: win_data = bus.wdata1;
      2'd2: win_data = bus.wdata2;
      2'd3: win_data = bus.wdata3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= 2'd3;
      tcnt        <= '0;
      gcnt        <= '0;
      bus.grant   <= '0;
      bus.ack     <= '0;
      bus.err     <= '0;
      bus.dev_sel <= '0;
      bus.m_start <= 1'b0;
      bus.m_data  <= '0;
      bus.m_abort <= 1'b0;
    end else begin
      bus.ack     <= '0;
      bus.err     <= '0;
      bus.m_start <= 1'b0;
      bus.m_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            bus.grant   <= 4'b0001 << win;
            bus.dev_sel <= win;
            bus.m_data  <= win_data;
            last_owner  <= win;
            state       <= START;
          end else begin
            bus.grant <= '0;
          end
        end
        START: begin
          bus.m_start <= 1'b1;
          tcnt        <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // m_done is tested first so it beats a same-cycle timeout.
          if (bus.m_done) begin
            bus.ack <= bus.grant;
            gcnt    <= '0;
            state   <= GAP;
          end else if (tcnt == 8'(TIMEOUT - 1)) begin
            bus.err     <= bus.grant;
            bus.m_abort <= 1'b1;
            gcnt        <= '0;
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        GAP: begin
          if (gcnt == 4'(GAP_CYCLES - 1)) begin
            bus.grant <= '0;
            state     <= IDLE;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter (GAP_CYCLES=2, TIMEOUT=255).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_spi_req_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_req_arbiter_if bus ();

  spi_req_arbiter #(
    .GAP_CYCLES(2),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.m_done = 1'b0;
    bus.wdata0 = 16'h1111;
    bus.wdata1 = 16'h2222;
    bus.wdata2 = 16'h3333;
    bus.wdata3 = 16'h4444;
    tick();
    tick();
    checks++;
    if ({bus.grant, bus.ack, bus.err, bus.dev_sel} !== 14'd0) begin
      errors++;
      $display("FAIL reset_vec: got %h want 0",
               {bus.grant, bus.ack, bus.err, bus.dev_sel});
    end
    checks++;
    if ({bus.m_start, bus.m_abort, bus.m_data} !== 18'd0) begin
      errors++;
      $display("FAIL reset_master: got %h want 0",
               {bus.m_start, bus.m_abort, bus.m_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.wdata0 = 16'hA569;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    checks++;
    if (bus.grant !== 4'b0001 || bus.dev_sel !== 2'd0) begin
      errors++;
      $display("FAIL single_grant: got %b/%0d want 0001/0",
               bus.grant, bus.dev_sel);
    end
    checks++;
    if (bus.m_data !== 16'hA569 || bus.m_start !== 1'b0) begin
      errors++;
      $display("FAIL single_data: got %h/%b want a569/0",
               bus.m_data, bus.m_start);
    end
    tick();
    checks++;
    if (bus.m_start !== 1'b1) begin
      errors++;
      $display("FAIL single_mstart: got %b want 1", bus.m_start);
    end
    repeat (17) tick();
    checks++;
    if (bus.ack !== 4'd0 || bus.m_start !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got ack %b mstart %b want 0",
               bus.ack, bus.m_start);
    end
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    checks++;
    if (bus.ack !== 4'b0001 || bus.err !== 4'd0) begin
      errors++;
      $display("FAIL single_ack: got %b/%b want 0001/0000",
               bus.ack, bus.err);
    end
    tick();
    checks++;
    if (bus.ack !== 4'd0 || bus.grant !== 4'b0001) begin
      errors++;
      $display("FAIL single_gap: got ack %b grant %b want 0/0001",
               bus.ack, bus.grant);
    end
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    checks++;
    if (bus.grant !== 4'd0) begin
      errors++;
      $display("FAIL single_release: got %b want 0", bus.grant);
    end
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    tick();
    checks++;
    if (bus.ack !== 4'd0 || bus.grant !== 4'd0) begin
      errors++;
      $display("FAIL stray_done: got ack %b grant %b want 0/0",
               bus.ack, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] wd [4];
    int exp_i;
    wd[0] = 16'hC000;
    wd[1] = 16'hC111;
    wd[2] = 16'hC222;
    wd[3] = 16'hC333;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wdata0 = wd[0];
    bus.wdata1 = wd[1];
    bus.wdata2 = wd[2];
    bus.wdata3 = wd[3];
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_i = k % 4;
      checks++;
      if (bus.grant !== (4'b0001 << exp_i)
          || bus.dev_sel !== 2'(exp_i)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b/%0d want req %0d",
                 k, bus.grant, bus.dev_sel, exp_i);
      end
      checks++;
      if (bus.m_data !== wd[exp_i]) begin
        errors++;
        $display("FAIL rr_data%0d: got %h want %h",
                 k, bus.m_data, wd[exp_i]);
      end
      tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      if (k == 4) bus.req = '0;
      checks++;
      if (bus.ack !== (4'b0001 << exp_i)) begin
        errors++;
        $display("FAIL rr_ack%0d: got %b want req %0d",
                 k, bus.ack, exp_i);
      end
      tick();
      checks++;
      if (bus.grant !== (4'b0001 << exp_i) || bus.ack !== 4'd0) begin
        errors++;
        $display("FAIL rr_gap%0d: got grant %b ack %b", k,
                 bus.grant, bus.ack);
      end
      tick();
      checks++;
      if (bus.grant !== 4'd0) begin
        errors++;
        $display("FAIL rr_idle%0d: got %b want 0", k, bus.grant);
      end
      tick();
    end
    checks++;
    if (bus.grant !== 4'd0) begin
      errors++;
      $display("FAIL rr_stop: got %b want 0", bus.grant);
    end
  endtask

  task automatic test_timeout();
    int bad;
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    checks++;
    if (bus.grant !== 4'b0100 || bus.dev_sel !== 2'd2) begin
      errors++;
      $display("FAIL to_grant: got %b/%0d want 0100/2",
               bus.grant, bus.dev_sel);
    end
    tick();
    bad = 0;
    for (int c = 0; c < 254; c++) begin
      tick();
      if ({bus.ack, bus.err, bus.m_abort} !== 9'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_early: got %0d bad cycles want 0", bad);
    end
    tick();
    checks++;
    if (bus.err !== 4'b0100 || bus.m_abort !== 1'b1
        || bus.ack !== 4'd0) begin
      errors++;
      $display("FAIL to_err: got err %b abort %b ack %b want 0100/1/0",
               bus.err, bus.m_abort, bus.ack);
    end
    tick();
    checks++;
    if (bus.err !== 4'd0 || bus.m_abort !== 1'b0
        || bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL to_pulse: got err %b abort %b grant %b",
               bus.err, bus.m_abort, bus.grant);
    end
    tick();
    checks++;
    if (bus.grant !== 4'd0) begin
      errors++;
      $display("FAIL to_idle: got %b want 0", bus.grant);
    end
  endtask

  task automatic test_coincident();
    bus.wdata1 = 16'h1234;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    bus.wdata1 = 16'h2563;
    checks++;
    if (bus.grant !== 4'b0010 || bus.m_data !== 16'h1234) begin
      errors++;
      $display("FAIL co_grant: got %b/%h want 0010/1234",
               bus.grant, bus.m_data);
    end
    tick();
    repeat (254) tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    checks++;
    if (bus.ack !== 4'b0010 || bus.err !== 4'd0
        || bus.m_abort !== 1'b0) begin
      errors++;
      $display("FAIL co_ack: got ack %b err %b abort %b want 0010/0/0",
               bus.ack, bus.err, bus.m_abort);
    end
    checks++;
    if (bus.m_data !== 16'h1234) begin
      errors++;
      $display("FAIL co_data: got %h want 1234", bus.m_data);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.wdata0 = 16'h0F0F;
    bus.wdata3 = 16'h3C3C;
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    repeat (5) tick();
    rst = 1'b1;
    bus.m_done = 1'b1;
    #1;
    checks++;
    if ({bus.grant, bus.ack, bus.err, bus.dev_sel, bus.m_start,
         bus.m_abort, bus.m_data} !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: outputs %h want 0",
               {bus.grant, bus.ack, bus.err, bus.dev_sel,
                bus.m_start, bus.m_abort, bus.m_data});
    end
    tick();
    bus.m_done = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if ({bus.ack, bus.err, bus.m_abort} !== 9'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_quiet: got %0d bad cycles want 0", bad);
    end
    bus.req = 4'b1001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.m_data !== 16'h0F0F) begin
      errors++;
      $display("FAIL rst_prio: got %b/%h want 0001/0f0f",
               bus.grant, bus.m_data);
    end
    bus.req = 4'b1000;
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.grant !== 4'b1000 || bus.dev_sel !== 2'd3
        || bus.m_data !== 16'h3C3C) begin
      errors++;
      $display("FAIL rst_next: got %b/%0d/%h want 1000/3/3c3c",
               bus.grant, bus.dev_sel, bus.m_data);
    end
    bus.req = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincident();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
